// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared constants and types for the fetch/decode front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Base-ISA major opcodes, Instruction[6:0]
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of {pc, instr} entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner, single-outstanding imem fetch FSM, decode buffer.
//               IFETCH_MISALIGN_CHK_EN adds the sticky MisalignErr output.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] InstrPC,
  output logic            InstrValid,
  input  logic            InstrReady,
  input  logic            BranchTaken,
  input  logic [XLEN-1:0] BranchTarget
`ifdef IFETCH_MISALIGN_CHK_EN
  ,
  output logic            MisalignErr
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    r_state;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_drop;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_halt;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic r_misalign;
  logic w_misalign_now;

  assign w_misalign_now = BranchTaken && (BranchTarget[1:0] != 2'b00);
  assign w_target       = BranchTarget;
  assign w_halt         = r_misalign || w_misalign_now;
  assign MisalignErr    = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= r_misalign || w_misalign_now;
  end
`else
  logic w_unused_tgt_lsb;

  assign w_unused_tgt_lsb = ^BranchTarget[1:0];
  assign w_target         = {BranchTarget[XLEN-1:2], 2'b00};
  assign w_halt           = 1'b0;
`endif

  assign w_next_pc = BranchTaken ? w_target : r_fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      if (BranchTaken) r_fetch_pc <= w_target;
      case (r_state)
        ST_IDLE: begin
          // A redirect empties the buffer, so it always leaves room.
          if (!w_halt && (BranchTaken || !w_fifo_full)) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_addr  <= w_next_pc;
          end
        end
        ST_REQ: begin
          if (BranchTaken) r_drop <= 1'b1;
          if (imem_gnt) begin
            r_state <= ST_WAIT;
            r_req   <= 1'b0;
            // With a drop pending fetch_pc already holds the redirect target.
            if (!BranchTaken && !r_drop) r_fetch_pc <= r_fetch_pc + XLEN'(4);
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
          end else if (BranchTaken) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign w_push       = (r_state == ST_WAIT) && imem_rvalid && !r_drop && !BranchTaken;
  assign w_push_entry = '{pc: r_addr, instr: imem_rdata};
  assign w_pop        = InstrValid && InstrReady;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (BranchTaken),
    .o_head       (w_head),
    .o_count      (w_fifo_count),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty)
  );

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign InstrValid  = (w_fifo_count != '0);
  assign Instruction = w_fifo_empty ? NOP_INSTR : w_head.instr;
  assign InstrPC     = w_fifo_empty ? RESET_PC : w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit with an in-order stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] c_reset_pc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        MisalignErr;
`endif

  instr_fetch_unit #(
    .RESET_PC   (c_reset_pc),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget)
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    .MisalignErr  (MisalignErr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: grant after gnt_delay waiting cycles, data rv_delay cycles later.
  int          gnt_delay = 0;
  int          rv_delay = 1;
  int          wait_cnt = 0;
  int          pcnt = 0;
  int          grants = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] last_gnt_addr = 32'h0;

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if (pend) begin
      pcnt++;
      if (pcnt >= rv_delay) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 1'b0;
      end
    end
    if (imem_req) begin
      if (wait_cnt >= gnt_delay) begin
        imem_gnt      = 1'b1;
        pend          = 1'b1;
        pcnt          = 0;
        paddr         = imem_addr;
        last_gnt_addr = imem_addr;
        grants++;
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Stream model: decode must see consecutive PCs from reset or the last redirect.
  logic [31:0] exp_pc = c_reset_pc;
  logic        prev_br = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, c_reset_pc);
      chk("rst_valid", InstrValid, 0);
      chk("rst_instr", Instruction, 32'h0000_0013);
      chk("rst_pc", InstrPC, c_reset_pc);
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("rst_misalign", MisalignErr, 0);
`endif
      exp_pc    = c_reset_pc;
      prev_br   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_br) chk("flush_empty", InstrValid, 0);
      if (prev_hold) begin
        chk("req_hold", imem_req, 1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (InstrValid && InstrReady) begin
        chk("deliver_pc", InstrPC, exp_pc);
        chk("deliver_instr", Instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (BranchTaken) begin
`ifdef IFETCH_MISALIGN_CHK_EN
        exp_pc = BranchTarget;
`else
        exp_pc = {BranchTarget[31:2], 2'b00};
`endif
      end
      prev_br   = BranchTaken;
      prev_hold = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic branch(input logic [31:0] t);
    BranchTaken  = 1'b1;
    BranchTarget = t;
    step();
    BranchTaken  = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int n;
    n = 0;
    while (!InstrValid && n < maxc) begin
      step();
      n++;
    end
    chk(name, InstrValid, 1);
  endtask

  task automatic wait_gnt(input string name, input int maxc);
    int n;
    n = 0;
    while (!imem_gnt && n < maxc) begin
      step();
      n++;
    end
    chk(name, imem_gnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a0;
    int          g0;
    int          n;

    // Reset and first fetches, decode stalled
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h100);
    step();
    chk("t1_not_yet", InstrValid, 0);
    step();
    chk("t1_valid", InstrValid, 1);
    chk("t1_pc", InstrPC, 32'h100);
    chk("t1_instr", Instruction, 32'h0001_0013);

    // Buffer fills to two entries, then one pop allows exactly one more fetch
    repeat (12) step();
    chk("t2_req_low", imem_req, 0);
    chk("t2_grants", grants, 2);
    chk("t2_head", InstrPC, 32'h100);
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    chk("t2_next_head", InstrPC, 32'h104);
    n = 0;
    while (!imem_req && n < 5) begin
      step();
      n++;
    end
    chk("t2_refetch_req", imem_req, 1);
    chk("t2_refetch_addr", imem_addr, 32'h108);
    repeat (10) step();
    chk("t2_grants_after", grants, 3);
    chk("t2_req_low_again", imem_req, 0);

    // Redirect while waiting for data
    InstrReady = 1'b1;
    rv_delay   = 3;
    repeat (4) step();
    wait_gnt("t3_gnt", 10);
    step();
    branch(32'h200);
    chk("t3_flushed", InstrValid, 0);
    wait_valid("t3_valid", 20);
    chk("t3_pc", InstrPC, 32'h200);
    chk("t3_instr", Instruction, 32'h0002_0013);
    rv_delay = 1;

    // Grant withheld for four cycles with a redirect inside the stall
    gnt_delay = 4;
    n = 0;
    while (!(imem_req && !imem_gnt) && n < 10) begin
      step();
      n++;
    end
    chk("t4_req", imem_req, 1);
    a0 = imem_addr;
    step();
    step();
    branch(32'h300);
    wait_gnt("t4_gnt", 10);
    chk("t4_old_addr_granted", last_gnt_addr, a0);
    gnt_delay = 0;
    wait_valid("t4_valid", 30);
    chk("t4_pc", InstrPC, 32'h300);

    // Redirect coinciding with returning data and a pop
    InstrReady = 1'b0;
    n = 0;
    while (!(imem_rvalid && InstrValid) && n < 30) begin
      step();
      n++;
    end
    chk("t5_setup", imem_rvalid && InstrValid, 1);
    InstrReady = 1'b1;
    branch(32'h400);
    chk("t5_flushed", InstrValid, 0);
    wait_valid("t5_valid", 20);
    chk("t5_pc", InstrPC, 32'h400);

    // Address wrap
    branch(32'hFFFF_FFFC);
    wait_valid("t7_valid_a", 20);
    chk("t7_pc_top", InstrPC, 32'hFFFF_FFFC);
    step();
    wait_valid("t7_valid_b", 20);
    chk("t7_pc_wrap", InstrPC, 32'h0);

    // Asynchronous reset mid-transaction; the late response must be ignored
    rv_delay = 3;
    wait_gnt("t6_gnt", 10);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_valid("t6_valid", 30);
    chk("t6_pc", InstrPC, c_reset_pc);
    chk("t6_instr", Instruction, 32'h0001_0013);
    rv_delay = 1;
    repeat (6) step();

`ifdef IFETCH_MISALIGN_CHK_EN
    branch(32'h202);
    chk("t8_err", MisalignErr, 1);
    repeat (6) step();
    g0 = grants;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t8_no_req", imem_req, 0);
    end
    chk("t8_no_grants", grants, g0);
    chk("t8_err_sticky", MisalignErr, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t8_req_after_reset", imem_req, 1);
    chk("t8_err_cleared", MisalignErr, 0);
`else
    g0 = grants;
    branch(32'h502);
    wait_valid("t8_valid", 20);
    chk("t8_pc_aligned", InstrPC, 32'h500);
    chk("t8_instr", Instruction, 32'h0005_0013);
    chk("t8_fetching", (grants > g0) ? 1 : 0, 1);
`endif
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
